// File: rtl/udp_loopback_pkt_buffer_pkg.sv
// udp_loopback_pkt_buffer shared types and defaults.
// TX state encoding, default geometry and length width.
package udp_loopback_pkg;
  localparam int ADDR_W_DEF    = 12;
  localparam int DESC_AW_DEF   = 3;
  localparam int GO_CYCLES_DEF = 3;
  localparam int LEN_W         = 16;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_GO   = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;
endpackage

// File: rtl/udp_loopback_pkt_buffer_if.sv
// Receiver/sender side signals of the UDP loopback packet buffer.
// master = receiver + sender environment, slave = the buffer.
interface udp_loopback_pkt_buffer_if #(
  parameter int DESC_AW = 3
);
  import udp_loopback_pkg::*;

  logic             rx_wr;
  logic [7:0]       rx_data;
  logic             rx_pkt_done;
  logic             rx_pkt_error;
  logic [LEN_W-1:0] rx_length;
  logic             tx_go;
  logic [LEN_W-1:0] tx_length;
  logic             tx_rd;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             pkt_dropped;
  logic [DESC_AW:0] pkt_count;

  modport master (
    output rx_wr, rx_data, rx_pkt_done, rx_pkt_error, rx_length,
    output tx_rd, tx_done,
    input  tx_go, tx_length, tx_data, pkt_dropped, pkt_count
  );

  modport slave (
    input  rx_wr, rx_data, rx_pkt_done, rx_pkt_error, rx_length,
    input  tx_rd, tx_done,
    output tx_go, tx_length, tx_data, pkt_dropped, pkt_count
  );
endinterface

// File: rtl/udp_loopback_pkt_buffer_desc_fifo.sv
// Descriptor FIFO holding one length word per committed packet.
// Show-ahead read: dout is the head entry whenever not empty.
module pkt_desc_fifo
  import udp_loopback_pkg::*;
#(
  parameter int AW = DESC_AW_DEF,
  parameter int W  = LEN_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(2 ** AW);

  logic [W-1:0]  mem [2 ** AW];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/udp_loopback_pkt_buffer.sv
// UDP loopback packet buffer: commit/rollback payload store,
// length descriptor queue and one-at-a-time sender launch.
module udp_loopback_pkt_buffer
  import udp_loopback_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DESC_AW   = DESC_AW_DEF,
  parameter int GO_CYCLES = GO_CYCLES_DEF
) (
  input logic Clk,
  input logic Rst,
  udp_loopback_pkt_buffer_if.slave io
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        ram [DEPTH];
  logic [7:0]        ram_q;
  logic [PW-1:0]     wr_ptr, wr_ptr_nx, wr_commit, rd_base, used;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  cur_len, fin_len, bytes_read, len_q;
  logic              bad, fin_bad, room, sat, wr_en, commit, drop_q;
  logic              f_pop, f_full, f_empty;
  logic [LEN_W-1:0]  f_dout;
  logic [DESC_AW:0]  f_count;
  logic              rd_en, src_ram;
  logic [7:0]        go_cnt;
  tx_state_e         state, state_nx;

  // Pointers carry one extra bit so a full RAM differs from an empty one
  assign used      = wr_ptr - rd_base;
  assign room      = (used != PW'(DEPTH));
  assign wr_en     = io.rx_wr & room;
  assign sat       = io.rx_wr & (cur_len == '1);
  assign fin_len   = (io.rx_wr & ~sat) ? cur_len + 16'd1 : cur_len;
  assign fin_bad   = bad | (io.rx_wr & ~room) | sat;
  assign wr_ptr_nx = wr_en ? wr_ptr + PW'(1) : wr_ptr;

  assign commit = io.rx_pkt_done & ~io.rx_pkt_error & ~fin_bad
                & (fin_len == io.rx_length) & (fin_len != '0)
                & ~f_full;

  always_ff @(posedge Clk) begin
    if (wr_en) ram[wr_ptr[ADDR_W-1:0]] <= io.rx_data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      cur_len   <= '0;
      bad       <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (io.rx_pkt_done) begin
        cur_len <= '0;
        bad     <= 1'b0;
        if (commit) begin
          wr_ptr    <= wr_ptr_nx;
          wr_commit <= wr_ptr_nx;
        end else begin
          wr_ptr <= wr_commit;
          drop_q <= 1'b1;
        end
      end else begin
        wr_ptr  <= wr_ptr_nx;
        cur_len <= fin_len;
        bad     <= fin_bad;
      end
    end
  end

  pkt_desc_fifo #(
    .AW (DESC_AW),
    .W  (LEN_W)
  ) u_desc (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (commit),
    .din   (fin_len),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= TX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    f_pop    = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (!f_empty) begin
          f_pop    = 1'b1;
          state_nx = TX_GO;
        end
      end
      TX_GO: begin
        if (go_cnt == 8'(GO_CYCLES - 1)) state_nx = TX_BUSY;
      end
      TX_BUSY: begin
        if (io.tx_done) state_nx = TX_IDLE;
      end
      default: state_nx = TX_IDLE;
    endcase
  end

  assign rd_en = io.tx_rd & (state != TX_IDLE) & (bytes_read < len_q);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      go_cnt     <= '0;
      len_q      <= '0;
      rd_base    <= '0;
      rd_ptr     <= '0;
      bytes_read <= '0;
      src_ram    <= 1'b0;
    end else begin
      go_cnt <= (state == TX_GO) ? go_cnt + 8'd1 : 8'd0;
      if (f_pop) begin
        len_q      <= f_dout;
        rd_ptr     <= rd_base[ADDR_W-1:0];
        bytes_read <= '0;
      end
      // Releasing the whole packet also discards any bytes left unread
      if (state == TX_BUSY && io.tx_done) begin
        rd_base <= rd_base + PW'(len_q);
      end
      if (rd_en) begin
        rd_ptr     <= rd_ptr + 1'b1;
        bytes_read <= bytes_read + 16'd1;
        src_ram    <= 1'b1;
      end else if (io.tx_rd) begin
        src_ram <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rd_en) ram_q <= ram[rd_ptr];
  end

  assign io.tx_go       = (state == TX_GO);
  assign io.tx_length   = len_q;
  assign io.tx_data     = src_ram ? ram_q : 8'h00;
  assign io.pkt_dropped = drop_q;
  assign io.pkt_count   = f_count;
endmodule

// File: tb/tb_udp_loopback_pkt_buffer.sv
// Self-checking bench for udp_loopback_pkt_buffer (ADDR_W=6).
// Queue-based packet model plus vector table and corner sequences.
module tb_udp_loopback_pkt_buffer;
  localparam int AW   = 6;
  localparam int DAW  = 3;
  localparam int CAP  = 1 << AW;
  localparam int DCAP = 1 << DAW;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  udp_loopback_pkt_buffer_if #(.DESC_AW(DAW)) io ();

  udp_loopback_pkt_buffer #(
    .ADDR_W    (AW),
    .DESC_AW   (DAW),
    .GO_CYCLES (3)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .io  (io)
  );

  always #4 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int drops = 0;
  int go_rises = 0;
  int exp_gos = 0;
  logic go_prev = 1'b0;

  int           mlens[$];
  byte unsigned mbytes[$];
  byte unsigned pbuf[$];
  int           occ = 0;
  bit           inflight = 0;

  typedef struct {
    int n;
    int len;
    bit err;
    bit merge;
    bit exp_drop;
  } vec_t;
  vec_t vecs[6];

  always @(negedge Clk) begin
    if (io.pkt_dropped) drops++;
    if (io.tx_go && !go_prev) go_rises++;
    go_prev = io.tx_go;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int n, input bit rnd, input int base);
    pbuf.delete();
    for (int i = 0; i < n; i++) begin
      if (rnd) pbuf.push_back(byte'($urandom_range(0, 255)));
      else     pbuf.push_back(byte'(base + i));
    end
  endtask

  task automatic tx_start(output int waited);
    int g;
    waited = 0;
    while (!io.tx_go && waited < 50) begin
      step();
      waited++;
    end
    exp_gos++;
    inflight = 1;
    if (!io.tx_go) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_go_timeout: got 0 expected 1");
      return;
    end
    if (mlens.size() > 0) chk("tx_length", io.tx_length, mlens[0]);
    g = 0;
    while (io.tx_go && g < 10) begin
      g++;
      step();
    end
    chk("go_width", g, 3);
  endtask

  task automatic tx_finish();
    int len;
    byte unsigned e, last;
    if (mlens.size() == 0) return;
    len = mlens.pop_front();
    last = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        io.tx_rd = 1'b0;
        step();
        chk("tx_hold", io.tx_data, last);
      end
      e = mbytes.pop_front();
      io.tx_rd = 1'b1;
      step();
      io.tx_rd = 1'b0;
      chk("tx_data", io.tx_data, e);
      last = e;
    end
    io.tx_rd = 1'b1;
    step();
    io.tx_rd = 1'b0;
    chk("tx_beyond", io.tx_data, 0);
    chk("tx_len_stable", io.tx_length, len);
    io.tx_done = 1'b1;
    step();
    io.tx_done = 1'b0;
    occ -= len;
    inflight = 0;
  endtask

  // Drive the packet in pbuf and compare against the model's verdict
  task automatic rx_and_check(input int len, input bit err, input bit merge,
                              input bit noise, output bit dropped);
    int n, q, d0, w;
    bit acc;
    n = pbuf.size();
    q = (mlens.size() > 0) ? mlens.size() - 1 : 0;
    acc = !err && n == len && n != 0 && occ + n <= CAP && q < DCAP;
    d0 = drops;
    for (int i = 0; i < n; i++) begin
      io.rx_wr = 1'b1;
      io.rx_data = pbuf[i];
      io.rx_pkt_error = noise && ($urandom_range(0, 7) == 0);
      if (merge && i == n - 1) begin
        io.rx_pkt_done = 1'b1;
        io.rx_pkt_error = err;
        io.rx_length = 16'(len);
      end
      step();
    end
    io.rx_wr = 1'b0;
    if (!merge || n == 0) begin
      io.rx_pkt_done = 1'b1;
      io.rx_pkt_error = err;
      io.rx_length = 16'(len);
      step();
    end
    io.rx_pkt_done = 1'b0;
    io.rx_pkt_error = 1'b0;
    step();
    dropped = (drops - d0) != 0;
    chk("drop_pulse", drops - d0, acc ? 0 : 1);
    if (acc) begin
      mlens.push_back(n);
      foreach (pbuf[i]) mbytes.push_back(pbuf[i]);
      occ += n;
    end
    q = (mlens.size() > 0) ? mlens.size() - 1 : 0;
    chk("pkt_count", io.pkt_count, q);
    if (acc && !inflight) tx_start(w);
  endtask

  task automatic drain();
    int w;
    while (mlens.size() > 0) begin
      if (!inflight) tx_start(w);
      tx_finish();
    end
    repeat (3) step();
    chk("drain_count", io.pkt_count, 0);
  endtask

  task automatic reset_check(input string tag);
    io.rx_wr = 1'b0;
    io.rx_pkt_done = 1'b0;
    io.rx_pkt_error = 1'b0;
    io.tx_rd = 1'b0;
    io.tx_done = 1'b0;
    #1 Rst = 1'b1;
    #1;
    chk({tag, "_go"}, io.tx_go, 0);
    chk({tag, "_len"}, io.tx_length, 0);
    chk({tag, "_data"}, io.tx_data, 0);
    chk({tag, "_drop"}, io.pkt_dropped, 0);
    chk({tag, "_count"}, io.pkt_count, 0);
    step();
    step();
    Rst = 1'b0;
    mlens.delete();
    mbytes.delete();
    occ = 0;
    inflight = 0;
    step();
  endtask

  initial begin
    int w, k, n, len;
    bit err, dr;

    vecs[0] = '{n: 10, len: 10, err: 1, merge: 0, exp_drop: 1};
    vecs[1] = '{n: 4,  len: 4,  err: 0, merge: 1, exp_drop: 0};
    vecs[2] = '{n: 20, len: 21, err: 0, merge: 0, exp_drop: 1};
    vecs[3] = '{n: 0,  len: 0,  err: 0, merge: 0, exp_drop: 1};
    vecs[4] = '{n: 5,  len: 4,  err: 0, merge: 1, exp_drop: 1};
    vecs[5] = '{n: 7,  len: 7,  err: 0, merge: 1, exp_drop: 0};

    io.rx_wr = 1'b0;
    io.rx_data = 8'h00;
    io.rx_pkt_done = 1'b0;
    io.rx_pkt_error = 1'b0;
    io.rx_length = 16'h0000;
    io.tx_rd = 1'b0;
    io.tx_done = 1'b0;
    repeat (3) step();
    chk("rst_go", io.tx_go, 0);
    chk("rst_len", io.tx_length, 0);
    chk("rst_data", io.tx_data, 0);
    chk("rst_drop", io.pkt_dropped, 0);
    chk("rst_count", io.pkt_count, 0);
    Rst = 1'b0;
    step();

    fill(18, 0, 0);
    rx_and_check(18, 0, 0, 0, dr);
    drain();

    foreach (vecs[i]) begin
      fill(vecs[i].n, 1, 0);
      rx_and_check(vecs[i].len, vecs[i].err, vecs[i].merge, 0, dr);
      chk("vec_drop", dr, vecs[i].exp_drop);
      drain();
      repeat (4) step();
      chk("vec_go_count", go_rises, exp_gos);
    end

    fill(70, 1, 0);
    rx_and_check(70, 0, 0, 0, dr);
    chk("ovf70_drop", dr, 1);
    fill(64, 1, 0);
    rx_and_check(64, 0, 1, 0, dr);
    chk("ovf64_keep", dr, 0);
    fill(1, 1, 0);
    rx_and_check(1, 0, 1, 0, dr);
    chk("ovf_extra_drop", dr, 1);
    drain();

    for (int p = 0; p < 8; p++) begin
      fill(1, 0, 8'h30 + p);
      rx_and_check(1, 0, 1, 0, dr);
    end
    chk("desc_count7", io.pkt_count, 7);
    fill(1, 0, 8'h38);
    rx_and_check(1, 0, 1, 0, dr);
    chk("desc_ninth", dr, 0);
    fill(1, 0, 8'h39);
    rx_and_check(1, 0, 1, 0, dr);
    chk("desc_tenth", dr, 1);
    tx_finish();
    while (mlens.size() > 0) begin
      tx_start(w);
      chk("go_gap", w, 1);
      tx_finish();
    end

    fill(12, 1, 0);
    for (int i = 0; i < 6; i++) begin
      io.rx_wr = 1'b1;
      io.rx_data = pbuf[i];
      step();
    end
    reset_check("rst_rx");

    fill(6, 0, 8'hA0);
    rx_and_check(6, 0, 0, 0, dr);
    fill(3, 0, 8'hC0);
    rx_and_check(3, 0, 1, 0, dr);
    io.tx_rd = 1'b1;
    step();
    chk("mid_tx_b0", io.tx_data, 8'hA0);
    step();
    chk("mid_tx_b1", io.tx_data, 8'hA1);
    io.tx_rd = 1'b0;
    reset_check("rst_tx");

    fill(5, 0, 8'h50);
    rx_and_check(5, 0, 0, 0, dr);
    drain();

    for (int r = 0; r < 30; r++) begin
      k = $urandom_range(1, 4);
      for (int p = 0; p < k; p++) begin
        n = $urandom_range(0, 30);
        len = n;
        if ($urandom_range(0, 5) == 0) len = n + 1;
        err = ($urandom_range(0, 5) == 0);
        fill(n, 1, 0);
        rx_and_check(len, err, 1'($urandom_range(0, 1)), 1, dr);
      end
      drain();
    end

    repeat (6) step();
    chk("final_go_count", go_rises, exp_gos);
    chk("final_count", io.pkt_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/udp_loopback_pkt_buffer.md
Name: udp_loopback_pkt_buffer

Overview:
- Sits between udp_gmii_rx and UDP_Send in the 125 MHz receive-clock domain; replaces the raw FIFO plus pulse-stretch path.
- Stores received UDP payload bytes and commits each packet only when it completes without error. Errored or overflowing packets are rolled back.
- Queues a length descriptor per committed packet, then starts UDP_Send one packet at a time with a stretched Go and its exact length.
- Supplies payload bytes on the sender's read requests.

Parameters:
- ADDR_W, 12, payload RAM address width; depth is 2^ADDR_W bytes.
- DESC_AW, 3, descriptor FIFO address width; depth is 2^DESC_AW packets.
- GO_CYCLES, 3, number of cycles tx_go is held high per packet.

Ports:
- Clk  in  1  the 125 MHz clock (clk125M_o); the only clock.
- Rst  in  1  asynchronous, active-high reset.
- rx_wr  in  1  payload byte valid, from udp_gmii_rx fifo_wr.
- rx_data  in  8  payload byte.
- rx_pkt_done  in  1  single-cycle end-of-packet pulse.
- rx_pkt_error  in  1  sampled with rx_pkt_done; 1 means the packet is bad.
- rx_length  in  16  payload length reported by the receiver; valid with rx_pkt_done.
- tx_go  out  1  start pulse to UDP_Send, high for GO_CYCLES cycles.
- tx_length  out  16  payload length of the packet being sent; stable from tx_go rise until tx_done.
- tx_rd  in  1  sender requests the next payload byte.
- tx_data  out  8  payload byte, valid the cycle after tx_rd.
- tx_done  in  1  single-cycle pulse from the sender when the packet is finished.
- pkt_dropped  out  1  single-cycle pulse each time a packet is discarded.
- pkt_count  out  DESC_AW+1  number of committed packets not yet sent.

Behaviour:
- Reset (Rst high, asynchronous): all pointers, counters and status outputs clear. tx_go=0, tx_length=0, tx_data=0, pkt_dropped=0, pkt_count=0. TX FSM goes to IDLE. A reset mid-packet discards the partial packet and any queued packets.
- RX pointers:
  - wr_ptr is the speculative write pointer; wr_commit marks the end of the last committed packet.
  - cur_len (16 bit) counts bytes of the current packet. It saturates at 16'hFFFF and sets the bad flag if it saturates.
- RX write rules:
  - Each rx_wr writes RAM[wr_ptr] and increments wr_ptr, which wraps at 2^ADDR_W.
  - Free space = 2^ADDR_W - (wr_ptr - rd_base), computed modulo.
  - If rx_wr arrives with free space = 0: the byte is not written and the packet's bad flag is set.
- Commit decision on rx_pkt_done. An rx_wr in the same cycle counts as part of the packet. The packet is committed only if all of these hold:
  - rx_pkt_error=0,
  - bad flag=0,
  - final count = rx_length,
  - final count != 0,
  - descriptor FIFO not full.
- On commit: push the final count into the descriptor FIFO, set wr_commit to wr_ptr, and clear cur_len and the bad flag.
- On drop: set wr_ptr back to wr_commit, pulse pkt_dropped for 1 cycle, and clear cur_len and the bad flag.
- rx_pkt_error without rx_pkt_done is ignored.
- TX FSM:
  - IDLE: when the descriptor FIFO is not empty, pop it, latch tx_length, and set rd_ptr to rd_base. Go to GO.
  - GO: tx_go=1 for GO_CYCLES cycles, then go to BUSY. tx_rd is honoured in GO.
  - BUSY: wait for tx_done. On tx_done set rd_base to rd_base + tx_length (modulo), which frees the space and discards unread bytes. Go to IDLE. The earliest next tx_go is 2 cycles later.
  - tx_done in IDLE or GO is ignored.
- TX reads:
  - On tx_rd with bytes_read < tx_length: tx_data gets RAM[rd_ptr] on the next clock, rd_ptr increments.
  - Reads beyond tx_length return 8'h00 and do not move rd_ptr.
  - tx_data holds its value when tx_rd=0.
- pkt_count: increments on push, decrements on pop. Simultaneous push and pop leaves it unchanged.
- The RAM is simple dual-port with a registered read, so it infers block RAM. A write and a read to the same address cannot occur, because committed space and in-flight packet space are disjoint.

Decomposition:
- Shared package udp_loopback_pkg holds:
  - the TX state encoding (IDLE, GO, BUSY),
  - the default ADDR_W, DESC_AW and GO_CYCLES constants,
  - the 16-bit length width constant.
- One sub-module, pkt_desc_fifo: a synchronous FIFO of length words with push, pop, full, empty and count.
- The payload RAM and the commit/rollback logic stay in the top module.

Test Plan:
- Single packet of 18 bytes 0x00..0x11 with rx_length=18 and error=0:
  - tx_go is high for 3 cycles and tx_length=18.
  - 18 tx_rd return 0x00..0x11, each one cycle late.
  - After tx_done, pkt_count=0.
- Packet of 10 bytes with rx_pkt_error=1, followed by a good 4-byte packet:
  - pkt_dropped pulses once.
  - Only one tx_go, with tx_length=4 and bytes equal to the second packet (no residue from the first).
- Length mismatch: 20 bytes with rx_length=21 -> the packet is dropped and no tx_go occurs.
- Overflow, ADDR_W=6: a 70-byte packet -> dropped.
  - Then a 64-byte packet -> accepted with correct data.
  - Then, with that packet still unsent, 1 more byte plus done -> dropped.
- Eight 1-byte packets with the sender withholding tx_done: pkt_count reaches 7 after the first pop.
  - A ninth and tenth packet: the ninth is accepted, the tenth is dropped.
  - Releasing tx_done then sends the remaining packets in order.
- Assert Rst mid-receive and again mid-transmission:
  - All outputs read 0 immediately.
  - A new 5-byte packet afterwards is sent correctly starting from address 0.
